// File: rtl/gray_bnry_decoder.sv
// Registered Gray-to-binary decoder with valid/ready handshake and a sticky
// adjacency checker. It flags any accepted code whose distance from the previous
// accepted code is not a single bit.
module gray_bnry_decoder #(
   parameter int unsigned SIZE      = 4,
   parameter bit          ALLOW_REP = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] gray_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] bin_out,
   output logic            step_err,
   input  logic            err_clr
);

   localparam int unsigned CNT_W = $clog2(SIZE + 1);

   logic [SIZE-1:0]  bin_c;
   logic [SIZE-1:0]  diff_c;
   logic [CNT_W-1:0] dist_c;
   logic             illegal_c;
   logic             accept_c;
   logic             deliver_c;
   logic [SIZE-1:0]  prev;
   logic             first;

   // Single-entry pipe: free when empty or when the held word leaves this cycle.
   // Reads 1 during reset because out_valid is cleared there.
   assign in_ready  = !out_valid | out_ready;
   assign accept_c  = in_valid & in_ready;
   assign deliver_c = out_valid & out_ready;

   // Prefix XOR from the MSB down: bit i is the parity of gray_in[SIZE-1:i].
   always_comb begin
      bin_c = '0;
      for (int i = 0; i < int'(SIZE); i++) begin
         bin_c[i] = ^(gray_in >> i);
      end
   end

   // Hamming distance to the previous accepted code and the legality decision.
   always_comb begin
      diff_c = gray_in ^ prev;
      dist_c = '0;
      for (int i = 0; i < int'(SIZE); i++) begin
         dist_c = dist_c + CNT_W'(diff_c[i]);
      end
      illegal_c = 1'b0;
      if (!first) begin
         if (dist_c > CNT_W'(1)) begin
            illegal_c = 1'b1;
         end else if ((dist_c == '0) && (ALLOW_REP == 1'b0)) begin
            illegal_c = 1'b1;
         end
      end
   end

   // Output register: load on accept, drain on delivery without a new accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         bin_out   <= '0;
      end else if (accept_c) begin
         out_valid <= 1'b1;
         bin_out   <= bin_c;
      end else if (deliver_c) begin
         out_valid <= 1'b0;
      end
   end

   // Previous-code tracking; the first accept after reset is never checked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= '0;
         first <= 1'b1;
      end else if (accept_c) begin
         prev  <= gray_in;
         first <= 1'b0;
      end
   end

   // Sticky step error; a set on the same edge as a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_err <= 1'b0;
      end else if (accept_c && illegal_c) begin
         step_err <= 1'b1;
      end else if (err_clr) begin
         step_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gray_bnry_decoder.sv
// Directed self-checking bench for gray_bnry_decoder. Two instances share all
// inputs: one allows repeated codes, the other flags them.
module tb_gray_bnry_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [3:0] gray_in;
   logic       err_clr;

   logic       in_ready,  out_valid,  step_err;
   logic [3:0] bin_out;
   logic       in_ready1, out_valid1, step_err1;
   logic [3:0] bin_out1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gray_bnry_decoder #(.SIZE(4), .ALLOW_REP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
      .bin_out(bin_out), .step_err(step_err), .err_clr(err_clr)
   );

   gray_bnry_decoder #(.SIZE(4), .ALLOW_REP(1'b0)) dut_norep (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .gray_in(gray_in), .out_valid(out_valid1), .out_ready(out_ready),
      .bin_out(bin_out1), .step_err(step_err1), .err_clr(err_clr)
   );

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one code for a single accepting edge.
   task automatic send(input logic [3:0] g);
      in_valid = 1'b1;
      gray_in  = g;
      step();
   endtask

   // Idle cycle with err_clr pulsed.
   task automatic clear_err();
      in_valid = 1'b0;
      err_clr  = 1'b1;
      step();
      err_clr  = 1'b0;
   endtask

   logic [3:0] t1_gray [7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b1100, 4'b1000};
   logic [3:0] t1_bin  [7] = '{4'd0,    4'd1,    4'd2,    4'd3,    4'd4,    4'd8,    4'd15};

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      gray_in   = '0;
      err_clr   = 1'b0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_bin_out",   32'(bin_out),   32'd0);
      check("rst_step_err",  32'(step_err),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Decode table, one cycle latency
      for (int i = 0; i < 7; i++) begin
         send(t1_gray[i]);
         check($sformatf("t1_bin_%0d", i), 32'(bin_out), 32'(t1_bin[i]));
         check($sformatf("t1_vld_%0d", i), 32'(out_valid), 32'd1);
      end
      // 0110 -> 1100 is a two-bit step
      check("t1_step_err", 32'(step_err), 32'd1);
      clear_err();
      check("t1_err_clr", 32'(step_err), 32'd0);
      check("t1_drain", 32'(out_valid), 32'd0);

      // Legal count run 0..15 then wrap to 0, full throughput
      for (int i = 0; i < 17; i++) begin
         send(4'((i % 16) ^ ((i % 16) >> 1)));
         check($sformatf("t2_bin_%0d", i), 32'(bin_out), 32'(i % 16));
      end
      check("t2_step_err", 32'(step_err), 32'd0);
      check("t2_step_err_norep", 32'(step_err1), 32'd0);

      // Illegal step, clear, clear colliding with a new illegal step
      send(4'b0010);
      check("t3_bin_a", 32'(bin_out), 32'd3);
      check("t3_err_a", 32'(step_err), 32'd0);
      send(4'b0111);
      check("t3_bin_b", 32'(bin_out), 32'd5);
      check("t3_err_b", 32'(step_err), 32'd1);
      clear_err();
      check("t3_err_clr", 32'(step_err), 32'd0);
      err_clr = 1'b1;
      send(4'b0010);
      err_clr = 1'b0;
      check("t3_set_wins", 32'(step_err), 32'd1);
      check("t3_bin_c", 32'(bin_out), 32'd3);
      clear_err();

      // Backpressure with 0110 pending
      out_ready = 1'b0;
      send(4'b0110);
      gray_in = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("t4_in_ready_%0d", i), 32'(in_ready), 32'd0);
         step();
         check($sformatf("t4_bin_%0d", i), 32'(bin_out), 32'd4);
         check($sformatf("t4_vld_%0d", i), 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      check("t4_in_ready_ret", 32'(in_ready), 32'd1);
      step();
      check("t4_next_bin", 32'(bin_out), 32'd5);
      check("t4_next_err", 32'(step_err), 32'd0);

      // Repeated code: legal on one instance, illegal on the other
      clear_err();
      send(4'b0011);
      check("t5_bin", 32'(bin_out), 32'd2);
      check("t5_first_norep", 32'(step_err1), 32'd0);
      send(4'b0011);
      check("t5_rep_allowed", 32'(step_err), 32'd0);
      check("t5_rep_flagged", 32'(step_err1), 32'd1);

      // Reset while a word is in flight
      check("t6_pre_vld", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("t6_rst_vld", 32'(out_valid), 32'd0);
      check("t6_rst_err", 32'(step_err1), 32'd0);
      check("t6_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      send(4'b1010);
      check("t6_bin", 32'(bin_out), 32'hC);
      check("t6_no_err", 32'(step_err), 32'd0);
      check("t6_no_err_norep", 32'(step_err1), 32'd0);

      // Delivery without accept drops valid and holds data
      in_valid = 1'b0;
      step();
      check("t7_vld", 32'(out_valid), 32'd0);
      check("t7_hold", 32'(bin_out), 32'hC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
